instr_prefetch: RTL and testbench
=================================

// Module: instr_prefetch
// PURPOSE
//  Fetch front end upstream of the single-cycle MIPS core datapath.
//  Owns the fetch PC and issues word reads to a multi-cycle instruction memory over a req/ack handshake.
//  Buffers returned words with their PCs in a small FIFO and presents them to decode over valid/ready.
//  Flushes the FIFO and restarts fetch on a branch/jump redirect from Next_PC.
// PARAMETERS
//  DEPTH     4             FIFO entries, power of two, >= 2
//  RESET_PC  32'h00000000  first fetch address after reset
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   asynchronous reset, active-low (0 = reset)
//  imem_req        out  1   read request, held high until imem_ack
//  imem_addr       out  32  word address, [1:0] always 2'b00
//  imem_ack        in   1   one-cycle pulse: imem_rdata valid
//  imem_rdata      in   32  instruction word
//  redirect_valid  in   1   one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   32  new PC, [1:0] ignored (forced 0)
//  instr_valid     out  1   head entry valid
//  instr           out  32  head instruction
//  instr_pc        out  32  PC of head instruction
//  instr_ready     in   1   decode consumes head when instr_valid & instr_ready
// BEHAVIOUR
//  Reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
//   FIFO empty, fetch_pc=RESET_PC, state IDLE.
//  States:
//   IDLE -> WAIT when count + 0 < DEPTH (space exists). Raise req, drive addr=fetch_pc.
//   WAIT: req=1, addr stable. On ack, push {fetch_pc, rdata}, fetch_pc += 4 (wraps mod 2^32).
//    Next state IDLE; a back-to-back req is allowed on the following cycle.
//   DISCARD: entered on redirect while in WAIT without same-cycle ack.
//    req stays high with the old addr until ack. The ack is dropped, then IDLE.
//  Max one outstanding request. Credit check counts the pending entry, so the FIFO never overflows.
//  Pop: on instr_valid & instr_ready, head advances. Outputs are registered FIFO head.
//   Latency ack -> instr_valid is 1 cycle.
//  Redirect (priority over ack, push, pop):
//   - Flush FIFO; instr_valid=0 next cycle.
//   - fetch_pc = {redirect_pc[31:2], 2'b00}.
//   - IDLE -> IDLE, next req next cycle.
//   - WAIT with same-cycle ack -> data dropped, IDLE.
//   - WAIT without ack -> DISCARD.
//   - DISCARD -> DISCARD with new fetch_pc.
//  Simultaneous push and pop when full: legal only if credit allowed the req; count unchanged.
//  Reset mid-transaction: everything returns to reset values immediately.
//   A late ack after reset is ignored because state is IDLE.
// CONFIGURATION
//  PREFETCH_BYPASS_EN defined:
//   - In WAIT with FIFO empty, imem_ack drives instr_valid/instr/instr_pc combinationally the same cycle.
//   - If instr_ready, the word is not pushed; otherwise it is pushed normally.
//   - Redirect still suppresses the bypass.
//  Undefined: outputs purely registered from FIFO, 1-cycle ack-to-valid latency.
// STRUCTURE
//  Package mips_fetch_pkg:
//   - state encoding localparams (IDLE/WAIT/DISCARD)
//   - RESET_PC default and PC increment constant 4
//   - entry width 64 ({pc,instr})
//  Sub-module fetch_fifo:
//   - DEPTH x 64 entries, push/pop/flush ports, count, head output
//   - registered pointers that wrap at DEPTH
//  FSM, fetch_pc and redirect logic stay in instr_prefetch.
// TESTING
//  1 Reset release, imem_ack 2 cycles after each req, instr_ready=1:
//    addrs 0,4,8,... issued; instr_pc follows the same sequence in order.
//  2 instr_ready=0 for 20 cycles: exactly DEPTH pushes, then imem_req stays 0.
//    Ready=1 then drains the FIFO in order with no loss or duplication.
//  3 Redirect to 0x40 while WAIT on addr 0x8, ack 3 cycles later:
//    the 0x8 data never appears; next req addr=0x40; first instr_pc=0x40.
//  4 Redirect and ack on the same cycle:
//    data dropped, instr_valid=0 next cycle, next req addr=redirect target.
//  5 Redirect to 0xFFFFFFFC: fetches 0xFFFFFFFC then 0x00000000 (wrap).
//    Redirect to 0x13 fetches 0x10.
//  6 Assert rst during WAIT, then ack arrives:
//    ack ignored, outputs at reset values, first req after release addr=RESET_PC.
//    Repeat 1 with PREFETCH_BYPASS_EN: instr_valid rises in the ack cycle.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
// Consumed by fetch_fifo and instr_prefetch.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam int          ENTRY_W          = 64;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of {pc, instr} entries for the prefetch buffer.
// Pointers are DEPTH-wrapping; head is read straight from the storage array.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ENTRY_W-1:0]       head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is reset too so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_prefetch.sv
// Fetch front end: owns fetch PC, issues imem reads, buffers words for decode.
// Optional PREFETCH_BYPASS_EN forwards an ack straight to decode when the buffer is empty.
//
// state      | meaning
// IDLE       | no request outstanding; launches one when the buffer has room
// WAIT       | request outstanding, returned word will be kept
// DISCARD    | request outstanding but redirected away; returned word is dropped
module instr_prefetch
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e        state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         redirect_tgt;
    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  fifo_head;
    logic                fifo_valid;
    logic                has_space;
    logic                push_req;
    logic                fifo_push;
    logic                fifo_pop;
    logic                bypass_hit;

    assign redirect_tgt = word_align(redirect_pc);
    assign fifo_valid   = (fifo_count != '0);
    // No request is in flight from IDLE, so the raw count is the full credit check.
    assign has_space    = (fifo_count < CNT_W'(DEPTH));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                end else if (has_space) begin
                    state_d = ST_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                    state_d    = imem_ack ? ST_IDLE : ST_DISCARD;
                end else if (imem_ack) begin
                    push_req   = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_INCR;
                    state_d    = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                end
                // The ack retires the stale request even if a new redirect lands with it.
                if (imem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    assign imem_req  = (state_q != ST_IDLE);
    assign imem_addr = addr_q;

`ifdef PREFETCH_BYPASS_EN
    assign bypass_hit  = (state_q == ST_WAIT) && imem_ack && !redirect_valid && !fifo_valid;
    assign instr_valid = fifo_valid || bypass_hit;
    assign instr       = bypass_hit ? imem_rdata : fifo_head[31:0];
    assign instr_pc    = bypass_hit ? addr_q : fifo_head[63:32];
`else
    assign bypass_hit  = 1'b0;
    assign instr_valid = fifo_valid;
    assign instr       = fifo_head[31:0];
    assign instr_pc    = fifo_head[63:32];
`endif

    assign fifo_push = push_req && !(bypass_hit && instr_ready);
    assign fifo_pop  = fifo_valid && instr_ready && !redirect_valid;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({addr_q, imem_rdata}),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed self-checking bench for instr_prefetch (DEPTH=4, RESET_PC=0).
// Honours PREFETCH_BYPASS_EN when the design is built with it.
module tb_instr_prefetch;

`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    instr_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, exp_addr);
    endtask

    // chk: buffer empty and decode ready, so this word must reach decode next.
    task automatic give_ack(input string tag, input logic [31:0] a, input int lat, input bit chk);
        repeat (lat) step();
        imem_ack   = 1'b1;
        imem_rdata = word(a);
        if (chk) begin
            #1;
            check({tag, "_ackcyc_valid"}, {31'd0, instr_valid}, {31'd0, BYP});
            if (BYP) begin
                check({tag, "_byp_instr"}, instr, word(a));
                check({tag, "_byp_pc"}, instr_pc, a);
            end
        end
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        if (chk) begin
            if (!BYP) begin
                check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
                check({tag, "_instr"}, instr, word(a));
                check({tag, "_pc"}, instr_pc, a);
            end else begin
                check({tag, "_after_valid"}, {31'd0, instr_valid}, 32'd0);
            end
        end
    endtask

    initial begin
        // reset values while held in reset
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);

        // 1: sequential fetch with ack 2 cycles after req, decode always ready
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req($sformatf("t1_%0d", i), 32'(i * 4));
            give_ack($sformatf("t1_%0d", i), 32'(i * 4), 2, 1'b1);
        end

        // 2: decode stalled: exactly 4 pushes, then no further request, then in-order drain
        do_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_req($sformatf("t2_%0d", i), 32'(i * 4));
            give_ack($sformatf("t2_%0d", i), 32'(i * 4), 2, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t2_full_noreq_%0d", i), {31'd0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_drain_valid_%0d", i), {31'd0, instr_valid}, 32'd1);
            check($sformatf("t2_drain_pc_%0d", i), instr_pc, 32'(i * 4));
            check($sformatf("t2_drain_instr_%0d", i), instr, word(32'(i * 4)));
            step();
        end
        check("t2_empty", {31'd0, instr_valid}, 32'd0);

        // 3: redirect to 0x40 while waiting on 0x8, stale ack 3 cycles later
        do_reset();
        instr_ready = 1'b1;
        wait_req("t3_0", 32'h0);
        give_ack("t3_0", 32'h0, 2, 1'b1);
        wait_req("t3_4", 32'h4);
        give_ack("t3_4", 32'h4, 2, 1'b1);
        wait_req("t3_8", 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("t3_disc_req", {31'd0, imem_req}, 32'd1);
        check("t3_disc_addr", imem_addr, 32'h8);
        repeat (2) step();
        imem_ack   = 1'b1;
        imem_rdata = word(32'h8);
        #1;
        check("t3_stale_ackcyc_valid", {31'd0, instr_valid}, 32'd0);
        step();
        imem_ack = 1'b0;
        check("t3_stale_dropped", {31'd0, instr_valid}, 32'd0);
        wait_req("t3_40", 32'h40);
        give_ack("t3_40", 32'h40, 2, 1'b1);

        // 4: redirect coincident with ack, buffer holding an entry
        do_reset();
        instr_ready = 1'b0;
        wait_req("t4_0", 32'h0);
        give_ack("t4_0", 32'h0, 2, 1'b0);
        check("t4_held_valid", {31'd0, instr_valid}, 32'd1);
        wait_req("t4_4", 32'h4);
        step();
        imem_ack       = 1'b1;
        imem_rdata     = word(32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        check("t4_flush_valid", {31'd0, instr_valid}, 32'd0);
        check("t4_idle_req", {31'd0, imem_req}, 32'd0);
        instr_ready = 1'b1;
        wait_req("t4_80", 32'h80);
        give_ack("t4_80", 32'h80, 2, 1'b1);

        // 5: redirect from IDLE to top of address space, wrap, then unaligned target
        rst            = 1'b0;
        redirect_valid = 1'b0;
        step();
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("t5_idle_redirect_noreq", {31'd0, imem_req}, 32'd0);
        wait_req("t5_top", 32'hFFFF_FFFC);
        give_ack("t5_top", 32'hFFFF_FFFC, 2, 1'b1);
        wait_req("t5_wrap", 32'h0);
        give_ack("t5_wrap", 32'h0, 2, 1'b1);
        wait_req("t5_4", 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h13;
        step();
        redirect_valid = 1'b0;
        check("t5_disc_addr", imem_addr, 32'h4);
        give_ack("t5_disc", 32'h4, 1, 1'b0);
        check("t5_disc_dropped", {31'd0, instr_valid}, 32'd0);
        wait_req("t5_align", 32'h10);
        give_ack("t5_align", 32'h10, 2, 1'b1);

        // 6: reset in WAIT, late ack after release is ignored
        do_reset();
        instr_ready = 1'b0;
        wait_req("t6_0", 32'h0);
        give_ack("t6_0", 32'h0, 2, 1'b0);
        wait_req("t6_4", 32'h4);
        step();
        rst = 1'b0;
        #1;
        check("t6_rst_req", {31'd0, imem_req}, 32'd0);
        check("t6_rst_addr", imem_addr, 32'h0);
        check("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("t6_rst_instr", instr, 32'h0);
        check("t6_rst_pc", instr_pc, 32'h0);
        step();
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = word(32'h4);
        step();
        imem_ack = 1'b0;
        check("t6_late_ack_valid", {31'd0, instr_valid}, 32'd0);
        wait_req("t6_restart", 32'h0);
        give_ack("t6_restart", 32'h0, 2, 1'b0);
        check("t6_restart_valid", {31'd0, instr_valid}, 32'd1);
        check("t6_restart_pc", instr_pc, 32'h0);
        check("t6_restart_instr", instr, word(32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
